// File: rtl/cache_mem_arbiter.sv
// Arbitrates one physical-memory port between the I-cache and D-cache miss paths.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on conflicts (default: D-cache always wins).
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              arb_conflict_inc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  // Read data goes to both caches; only the matching resp qualifies it.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic {
    RR_D = 1'b0,
    RR_I = 1'b1
  } rr_e;

  rr_e rr_last_q, rr_last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= RR_D;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    i_pmem_resp      = 1'b0;
    d_pmem_resp      = 1'b0;
    arb_conflict_inc = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d        = rr_last_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          arb_conflict_inc = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          state_d = (rr_last_q == RR_D) ? SERVE_I : SERVE_D;
`else
          state_d = SERVE_D;
`endif
        end else if (d_req) begin
          state_d = SERVE_D;
        end else if (i_req) begin
          state_d = SERVE_I;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (state_d == SERVE_I) rr_last_d = RR_I;
        if (state_d == SERVE_D) rr_last_d = RR_D;
`endif
      end
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        // Writeback wins over a simultaneous fill; the fill is re-requested later.
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        if (pmem_resp) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset kills strobes and discards any resp in the same cycle.
    if (rst) begin
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      i_pmem_resp      = 1'b0;
      d_pmem_resp      = 1'b0;
      arb_conflict_inc = 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// traffic checked against an owner-based reference model.
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              arb_conflict_inc;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_pmem_read     (i_pmem_read),
    .i_pmem_address  (i_pmem_address),
    .i_pmem_rdata    (i_pmem_rdata),
    .i_pmem_resp     (i_pmem_resp),
    .d_pmem_read     (d_pmem_read),
    .d_pmem_write    (d_pmem_write),
    .d_pmem_address  (d_pmem_address),
    .d_pmem_wdata    (d_pmem_wdata),
    .d_pmem_rdata    (d_pmem_rdata),
    .d_pmem_resp     (d_pmem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .arb_conflict_inc(arb_conflict_inc)
  );

  always #5 clk = ~clk;

  // Control bits: {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, arb_conflict_inc}
  function automatic logic [4:0] ctl();
    return {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, arb_conflict_inc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_pmem_read    = 1'b0;
    i_pmem_address = '0;
    d_pmem_read    = 1'b0;
    d_pmem_write   = 1'b0;
    d_pmem_address = '0;
    d_pmem_wdata   = '0;
    pmem_rdata     = '0;
    pmem_resp      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    pmem_resp   = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      settle();
      checks++;
      if (ctl() !== 5'b00000) begin
        errors++;
        $display("FAIL reset_ctl cyc%0d got %b exp 00000", c, ctl());
      end
    end
    clear_inputs();
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if (ctl() !== 5'b00000 || pmem_address !== '0 || pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_after got ctl=%b addr=%h exp ctl=00000 addr=0", ctl(), pmem_address);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      tick();
      pmem_resp  = (c == 4);
      pmem_rdata = {4{$urandom}};
      settle();
      checks++;
      if (ctl() !== 5'b00000 || pmem_address !== '0 || pmem_wdata !== '0) begin
        errors++;
        $display("FAIL idle cyc%0d got ctl=%b addr=%h exp ctl=00000 addr=0", c, ctl(), pmem_address);
      end
    end
    pmem_resp = 1'b0;
  endtask

  task automatic test_i_fill();
    tick();
    i_pmem_read    = 1'b1;
    i_pmem_address = 16'h1230;
    settle();
    checks++;
    if (ctl() !== 5'b00000) begin
      errors++;
      $display("FAIL ifill_c0 got %b exp 00000", ctl());
    end
    for (int c = 1; c <= 4; c++) begin
      tick();
      settle();
      checks++;
      if (ctl() !== 5'b10000 || pmem_address !== 16'h1230) begin
        errors++;
        $display("FAIL ifill_wait cyc%0d got ctl=%b addr=%h exp ctl=10000 addr=1230", c, ctl(), pmem_address);
      end
    end
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = {16{8'hA5}};
    settle();
    checks++;
    if (ctl() !== 5'b10100 || i_pmem_rdata !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL ifill_resp got ctl=%b rdata=%h exp ctl=10100 rdata=a5..a5", ctl(), i_pmem_rdata);
    end
    tick();
    pmem_resp   = 1'b0;
    i_pmem_read = 1'b0;
    settle();
    checks++;
    if (ctl() !== 5'b00000 || pmem_address !== '0) begin
      errors++;
      $display("FAIL ifill_idle got ctl=%b addr=%h exp ctl=00000 addr=0", ctl(), pmem_address);
    end
  endtask

  // Last grant before this test was I, so both builds grant D first here.
  task automatic test_conflict();
    logic [4:0] exp_c [6] = '{5'b00001, 5'b10000, 5'b10010, 5'b00000, 5'b10100, 5'b00000};
    logic [ADDR_W-1:0] exp_a [6] = '{16'h0, 16'h2220, 16'h2220, 16'h0, 16'h1110, 16'h0};
    for (int c = 0; c < 6; c++) begin
      tick();
      i_pmem_read    = (c <= 4);
      i_pmem_address = 16'h1110;
      d_pmem_read    = (c <= 2);
      d_pmem_address = 16'h2220;
      pmem_resp      = (c == 2) || (c == 4);
      settle();
      checks++;
      if (ctl() !== exp_c[c] || pmem_address !== exp_a[c]) begin
        errors++;
        $display("FAIL conflict cyc%0d got ctl=%b addr=%h exp ctl=%b addr=%h",
                 c, ctl(), pmem_address, exp_c[c], exp_a[c]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_writeback();
    logic [4:0] exp_c [5] = '{5'b00000, 5'b01000, 5'b01000, 5'b01010, 5'b00000};
    logic [LINE_W-1:0] wd;
    wd = {16{8'h11}};
    for (int c = 0; c < 5; c++) begin
      tick();
      d_pmem_write   = (c <= 3);
      d_pmem_read    = (c == 2) || (c == 3);
      d_pmem_address = 16'h4F00;
      d_pmem_wdata   = wd;
      pmem_resp      = (c == 3);
      settle();
      checks++;
      if (ctl() !== exp_c[c]) begin
        errors++;
        $display("FAIL wb_ctl cyc%0d got %b exp %b", c, ctl(), exp_c[c]);
      end
      checks++;
      if ((c >= 1 && c <= 3) ? (pmem_wdata !== wd || pmem_address !== 16'h4F00)
                             : (pmem_wdata !== '0)) begin
        errors++;
        $display("FAIL wb_data cyc%0d got wdata=%h addr=%h", c, pmem_wdata, pmem_address);
      end
    end
    clear_inputs();
  endtask

  task automatic test_rst_mid();
    logic [4:0] exp_c [7] = '{5'b00000, 5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b10100, 5'b00000};
    for (int c = 0; c < 7; c++) begin
      tick();
      i_pmem_read    = (c <= 5);
      i_pmem_address = 16'h0BC0;
      rst            = (c == 3);
      pmem_resp      = (c == 3) || (c == 5);
      settle();
      checks++;
      if (ctl() !== exp_c[c]) begin
        errors++;
        $display("FAIL rst_mid cyc%0d got %b exp %b", c, ctl(), exp_c[c]);
      end
      if (c == 4) begin
        checks++;
        if (pmem_address !== '0) begin
          errors++;
          $display("FAIL rst_mid_addr got %h exp 0", pmem_address);
        end
      end
    end
    clear_inputs();
  endtask

  // Owner model: 0 = nobody, 1 = I-cache, 2 = D-cache.
  task automatic test_random();
    int owner, owner_n, rr, rr_n;
    bit saw_i, saw_d, i_want, d_want;
    logic [4:0] exp_c;
    logic [ADDR_W-1:0] exp_a;
    logic [LINE_W-1:0] exp_w;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst     = 1'b0;
    owner_n = 0;
    rr_n    = 2;
    saw_i   = 1'b0;
    saw_d   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      owner = owner_n;
      rr    = rr_n;
      if (saw_i) i_pmem_read = 1'b0;
      else if (!i_pmem_read && ($urandom_range(0, 2) == 0)) begin
        i_pmem_read    = 1'b1;
        i_pmem_address = ADDR_W'($urandom);
      end
      if (saw_d) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else if (!(d_pmem_read || d_pmem_write) && ($urandom_range(0, 2) == 0)) begin
        int k;
        k              = $urandom_range(0, 3);
        d_pmem_read    = (k != 1);
        d_pmem_write   = (k == 1) || (k == 2);
        d_pmem_address = ADDR_W'($urandom);
        d_pmem_wdata   = {4{$urandom}};
      end
      pmem_resp  = ($urandom_range(0, 3) == 0);
      pmem_rdata = {4{$urandom}};
      settle();

      i_want = i_pmem_read;
      d_want = d_pmem_read || d_pmem_write;
      exp_c  = {(owner == 1) || (owner == 2 && d_pmem_read && !d_pmem_write),
                owner == 2 && d_pmem_write,
                owner == 1 && pmem_resp,
                owner == 2 && pmem_resp,
                owner == 0 && i_want && d_want};
      exp_a  = (owner == 1) ? i_pmem_address : (owner == 2) ? d_pmem_address : '0;
      exp_w  = (owner == 2) ? d_pmem_wdata : '0;

      checks++;
      if (ctl() !== exp_c) begin
        errors++;
        $display("FAIL rand_ctl cyc%0d owner%0d got %b exp %b", c, owner, ctl(), exp_c);
      end
      checks++;
      if (pmem_address !== exp_a) begin
        errors++;
        $display("FAIL rand_addr cyc%0d got %h exp %h", c, pmem_address, exp_a);
      end
      checks++;
      if (pmem_wdata !== exp_w) begin
        errors++;
        $display("FAIL rand_wdata cyc%0d got %h exp %h", c, pmem_wdata, exp_w);
      end
      checks++;
      if (i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata) begin
        errors++;
        $display("FAIL rand_rdata cyc%0d got i=%h d=%h exp %h", c, i_pmem_rdata, d_pmem_rdata, pmem_rdata);
      end

      saw_i = exp_c[2];
      saw_d = exp_c[1];
      if (owner != 0) begin
        owner_n = pmem_resp ? 0 : owner;
      end else if (i_want && d_want) begin
`ifdef ARB_ROUND_ROBIN_EN
        owner_n = (rr == 2) ? 1 : 2;
`else
        owner_n = 2;
`endif
      end else if (d_want) begin
        owner_n = 2;
      end else if (i_want) begin
        owner_n = 1;
      end else begin
        owner_n = 0;
      end
      rr_n = (owner == 0 && owner_n != 0) ? owner_n : rr;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_idle();
    test_i_fill();
    test_conflict();
    test_writeback();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
